// File: rtl/irq_event_ctrl.sv
// irq_event_ctrl
//   APB-programmable interrupt/event controller placed in front of the sleep unit.
//   Each rising edge on a request line sets a pending bit. Pending bits are ANDed
//   with the mask, and the lowest-index active bit is presented to the core.
//   signal_o drives the wake/abort input of the sleep unit.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/   APB slave; word index PADDR[4:2]:
//   PSEL/PENABLE/PRDATA/     0 MASK (RW), 1 PENDING (RO), 2 SET (W1S),
//   PREADY/PSLVERR           3 CLEAR (W1C), 4 STATUS (RO: [31]=irq, [4:0]=id)
//   irq_lines_i            level request lines, synchronous to HCLK
//   irq_o, irq_id_o        request and lowest active index presented to the core
//   irq_ack_i/irq_ack_id_i single-cycle acknowledge of one index
//   signal_o               wake/abort to the sleep unit; same as irq_o
module irq_event_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_LINES       = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NB_LINES-1:0]       irq_lines_i,
  output logic                      irq_o,
  output logic [4:0]                irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [4:0]                irq_ack_id_i,
  output logic                      signal_o
);

  localparam logic [2:0] IDX_MASK    = 3'd0;
  localparam logic [2:0] IDX_PENDING = 3'd1;
  localparam logic [2:0] IDX_SET     = 3'd2;
  localparam logic [2:0] IDX_CLEAR   = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;

  logic [NB_LINES-1:0] mask_q, pending_q, prev_q;
  logic [NB_LINES-1:0] pending_n, edge_v, set_v, clr_v, ack_v, active_v;
  logic [2:0]          word_idx;
  logic                wr_en, rd_en;
  logic                unused_bits;

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign word_idx = PADDR[4:2];
  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign rd_en    = PSEL & PENABLE & ~PWRITE;

  // Only a few address bits and NB_LINES data bits take part in the decode.
  assign unused_bits = ^{PADDR, PWDATA};

  assign edge_v   = irq_lines_i & ~prev_q;
  assign active_v = pending_q & mask_q;

  // An ack whose id is outside 0..NB_LINES-1 matches no bit, so it does nothing.
  always_comb begin
    ack_v = '0;
    for (int i = 0; i < NB_LINES; i++) begin
      ack_v[i] = irq_ack_i && (irq_ack_id_i == 5'(i));
    end
  end

  // Set wins over clear, so an edge that lands in the ack cycle is kept.
  always_comb begin
    set_v     = edge_v | ((wr_en && word_idx == IDX_SET) ? PWDATA[NB_LINES-1:0] : '0);
    clr_v     = ack_v  | ((wr_en && word_idx == IDX_CLEAR) ? PWDATA[NB_LINES-1:0] : '0);
    pending_n = set_v | (pending_q & ~clr_v);
  end

  // Downward scan: the last assignment is the lowest set index.
  always_comb begin
    irq_id_o = 5'd0;
    for (int i = NB_LINES - 1; i >= 0; i--) begin
      if (active_v[i]) irq_id_o = 5'(i);
    end
  end

  assign irq_o    = |active_v;
  assign signal_o = irq_o;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_q    <= '0;
      pending_q <= '0;
      prev_q    <= '1;   // a line already high at reset release does not count as an edge
    end else begin
      prev_q    <= irq_lines_i;
      pending_q <= pending_n;
      if (wr_en && word_idx == IDX_MASK) mask_q <= PWDATA[NB_LINES-1:0];
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (rd_en) begin
      case (word_idx)
        IDX_MASK:    PRDATA = 32'(mask_q);
        IDX_PENDING: PRDATA = 32'(pending_q);
        IDX_STATUS:  PRDATA = {irq_o, 26'd0, irq_id_o};
        default:     PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_event_ctrl.sv
module tb_irq_event_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA, PRDATA8;
  logic        PREADY, PSLVERR, PREADY8, PSLVERR8;
  logic [31:0] irq_lines;
  logic        irq_o, signal_o, irq8, sig8;
  logic [4:0]  irq_id, id8;
  logic        ack;
  logic [4:0]  ack_id;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [11:0] A_MASK    = 12'h000;
  localparam logic [11:0] A_PENDING = 12'h004;
  localparam logic [11:0] A_SET     = 12'h008;
  localparam logic [11:0] A_CLEAR   = 12'h00C;
  localparam logic [11:0] A_STATUS  = 12'h010;
  localparam logic [11:0] A_UNMAP   = 12'h014;

  irq_event_ctrl #(.APB_ADDR_WIDTH(12), .NB_LINES(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_lines_i(irq_lines),
    .irq_o(irq_o), .irq_id_o(irq_id), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
    .signal_o(signal_o)
  );

  // Narrow instance on the same bus to exercise NB_LINES < 32 boundaries.
  irq_event_ctrl #(.APB_ADDR_WIDTH(12), .NB_LINES(8)) dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA8),
    .PREADY(PREADY8), .PSLVERR(PSLVERR8), .irq_lines_i(irq_lines[7:0]),
    .irq_o(irq8), .irq_id_o(id8), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
    .signal_o(sig8)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] d, output logic [31:0] d8);
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1;
    d = PRDATA; d8 = PRDATA8;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_ack(input logic [4:0] id);
    @(negedge HCLK);
    ack = 1'b1; ack_id = id;
    @(negedge HCLK);
    ack = 1'b0; ack_id = 5'd0;
  endtask

  task automatic test_reset;
    logic [31:0] d, d8;
    HRESETn = 1'b0; irq_lines = 32'h1; ack = 1'b0; ack_id = 5'd0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge HCLK);
    n_checks++;
    if ({irq_o, signal_o, irq_id, PRDATA} !== 39'd0) begin
      n_fail++; $display("FAIL reset_outputs: got irq=%b sig=%b id=%0d prdata=%h, want all 0", irq_o, signal_o, irq_id, PRDATA);
    end
    n_checks++;
    if ({PREADY, PSLVERR} !== 2'b10) begin
      n_fail++; $display("FAIL ready_slverr: got %b%b want 10", PREADY, PSLVERR);
    end
    HRESETn = 1'b1;
    apb_write(A_MASK, 32'hFFFF_FFFF);
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h0 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL held_line_no_edge: got pending=%h irq=%b want 0/0", d, irq_o);
    end
    @(negedge HCLK); irq_lines = 32'h0;
    @(negedge HCLK); irq_lines = 32'h1;
    @(negedge HCLK);
    n_checks++;
    if (irq_o !== 1'b1 || irq_id !== 5'd0) begin
      n_fail++; $display("FAIL line0_edge: got irq=%b id=%0d want 1/0", irq_o, irq_id);
    end
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL line0_pending: got %h want 00000001", d);
    end
    irq_lines = 32'h0;
    apb_write(A_CLEAR, 32'hFFFF_FFFF);
  endtask

  task automatic test_mask;
    logic [31:0] d, d8;
    apb_write(A_MASK, 32'h0);
    @(negedge HCLK); irq_lines = 32'h20;
    @(negedge HCLK); irq_lines = 32'h0;
    @(negedge HCLK);
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h20 || irq_o !== 1'b0 || signal_o !== 1'b0) begin
      n_fail++; $display("FAIL masked_pending: got pending=%h irq=%b sig=%b want 20/0/0", d, irq_o, signal_o);
    end
    apb_write(A_MASK, 32'h20);
    n_checks++;
    if (irq_o !== 1'b1 || irq_id !== 5'd5 || signal_o !== 1'b1) begin
      n_fail++; $display("FAIL unmask_irq: got irq=%b id=%0d sig=%b want 1/5/1", irq_o, irq_id, signal_o);
    end
    apb_read(A_STATUS, d, d8);
    n_checks++;
    if (d !== 32'h8000_0005) begin
      n_fail++; $display("FAIL status: got %h want 80000005", d);
    end
    apb_read(A_UNMAP, d, d8);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: got %h want 0", d);
    end
    apb_write(A_MASK, 32'h0);
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h20 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL mask_keeps_pending: got pending=%h irq=%b want 20/0", d, irq_o);
    end
    apb_write(A_CLEAR, 32'hFFFF_FFFF);
  endtask

  task automatic test_set_ack;
    logic [31:0] d, d8;
    apb_write(A_MASK, 32'hFFFF_FFFF);
    apb_write(A_SET, 32'h0000_0110);
    n_checks++;
    if (irq_o !== 1'b1 || irq_id !== 5'd4) begin
      n_fail++; $display("FAIL set_id4: got irq=%b id=%0d want 1/4", irq_o, irq_id);
    end
    apb_read(A_SET, d, d8);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL set_reads_zero: got %h want 0", d);
    end
    do_ack(5'd4);
    n_checks++;
    if (irq_o !== 1'b1 || irq_id !== 5'd8) begin
      n_fail++; $display("FAIL ack4_next: got irq=%b id=%0d want 1/8", irq_o, irq_id);
    end
    do_ack(5'd8);
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (irq_o !== 1'b0 || d !== 32'h0) begin
      n_fail++; $display("FAIL ack8_done: got irq=%b pending=%h want 0/0", irq_o, d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, d8;
    apb_write(A_SET, 32'h8);
    n_checks++;
    if (irq_id !== 5'd3) begin
      n_fail++; $display("FAIL set3_id: got %0d want 3", irq_id);
    end
    @(negedge HCLK);
    irq_lines = 32'h8; ack = 1'b1; ack_id = 5'd3;
    @(negedge HCLK);
    ack = 1'b0; ack_id = 5'd0;
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++; $display("FAIL edge_in_ack_irq: got %b want 1", irq_o);
    end
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h8) begin
      n_fail++; $display("FAIL edge_in_ack_pending: got %h want 00000008", d);
    end
    irq_lines = 32'h0;
    apb_write(A_CLEAR, 32'hFFFF_FFFF);
  endtask

  task automatic test_invalid_ack;
    logic [31:0] d, d8;
    apb_write(A_SET, 32'h8000_0004);
    do_ack(5'd7);
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h8000_0004 || d8 !== 32'h4) begin
      n_fail++; $display("FAIL ack_not_pending: got %h/%h want 80000004/00000004", d, d8);
    end
    do_ack(5'd31);
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h4 || d8 !== 32'h4) begin
      n_fail++; $display("FAIL ack31: got %h/%h want 00000004/00000004", d, d8);
    end
    apb_read(A_MASK, d, d8);
    n_checks++;
    if (d8 !== 32'hFF || d !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mask_width: got %h/%h want ffffffff/000000ff", d, d8);
    end
    apb_write(A_CLEAR, 32'h4);
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h0 || d8 !== 32'h0 || signal_o !== 1'b0 || sig8 !== 1'b0) begin
      n_fail++; $display("FAIL clear4: got %h/%h sig=%b/%b want 0/0 0/0", d, d8, signal_o, sig8);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d, d8;
    apb_write(A_SET, 32'h3);
    apb_write(A_MASK, 32'h3);
    n_checks++;
    if (irq_o !== 1'b1 || signal_o !== 1'b1 || irq_id !== 5'd0) begin
      n_fail++; $display("FAIL pre_reset: got irq=%b sig=%b id=%0d want 1/1/0", irq_o, signal_o, irq_id);
    end
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = A_PENDING;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1;
    n_checks++;
    if (PRDATA !== 32'h3) begin
      n_fail++; $display("FAIL pre_reset_read: got %h want 00000003", PRDATA);
    end
    #1 HRESETn = 1'b0;
    #1;
    n_checks++;
    if (irq_o !== 1'b0 || signal_o !== 1'b0 || PRDATA !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got irq=%b sig=%b prdata=%h want 0/0/0", irq_o, signal_o, PRDATA);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    apb_read(A_MASK, d, d8);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_mask: got %h want 0", d);
    end
    apb_read(A_PENDING, d, d8);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_pending: got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_set_ack();
    test_back_to_back();
    test_invalid_ack();
    test_async_reset();
    repeat (2) @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
